// File: rtl/otp_read_sequencer_if.sv
// rtl/otp_read_sequencer_if.sv - host single-byte read port of the OTP read sequencer
interface otp_read_sequencer_if;
  logic       hif_rd_req;
  logic [9:0] hif_rd_addr;
  logic       hif_rd_ack;
  logic [7:0] hif_rd_data;

  modport master (output hif_rd_req, hif_rd_addr, input hif_rd_ack, hif_rd_data);
  modport slave  (input hif_rd_req, hif_rd_addr, output hif_rd_ack, hif_rd_data);
endinterface

// File: rtl/otp_read_sequencer.sv
// rtl/otp_read_sequencer.sv - read-only eFuse sequencer: boot shadow load, then host byte reads
module otp_read_sequencer #(
  parameter int         NUM_SHADOW = 16,
  parameter logic [9:0] BOOT_BASE  = 10'h000,
  parameter int         T_SU       = 2,
  parameter int         T_STB      = 4,
  parameter int         T_HLD      = 2
) (
  input  logic                      xtal_clk,
  input  logic                      por_rst_n,
  output logic                      o_otp_csb,
  output logic                      o_otp_strobe,
  output logic                      o_otp_load,
  output logic                      o_otp_pgenb,
  output logic                      o_otp_vddqsw,
  output logic [9:0]                o_otp_addr,
  input  logic [7:0]                i_otp_q,
  input  logic                      otp_reload,
  otp_read_sequencer_if.slave       hif,
  output logic [8*NUM_SHADOW-1:0]   shadow_data,
  output logic                      load_done,
  output logic                      busy
);

  localparam int TMAX = (T_SU > T_STB) ? ((T_SU > T_HLD) ? T_SU : T_HLD)
                                       : ((T_STB > T_HLD) ? T_STB : T_HLD);
  localparam int CW = $clog2(TMAX + 1);
  localparam int IW = (NUM_SHADOW > 1) ? $clog2(NUM_SHADOW) : 1;

  localparam logic [CW-1:0] SU_LAST  = CW'(T_SU - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(T_STB - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(T_HLD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_SHADOW - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          host_mode;
  logic          reload_pend;

  // Programming path is never exercised by this block.
  assign o_otp_pgenb  = 1'b1;
  assign o_otp_vddqsw = 1'b0;
  assign busy         = (state != ST_IDLE);

  // reload_pend resets high so the boot load starts on the first cycle after reset.
  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      idx             <= '0;
      host_mode       <= 1'b0;
      reload_pend     <= 1'b1;
      o_otp_csb       <= 1'b1;
      o_otp_strobe    <= 1'b0;
      o_otp_load      <= 1'b0;
      o_otp_addr      <= '0;
      hif.hif_rd_ack  <= 1'b0;
      hif.hif_rd_data <= '0;
      shadow_data     <= '0;
      load_done       <= 1'b0;
    end else begin
      hif.hif_rd_ack <= 1'b0;
      if (otp_reload && state != ST_IDLE) reload_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (reload_pend || otp_reload) begin
            reload_pend <= 1'b0;
            load_done   <= 1'b0;
            host_mode   <= 1'b0;
            idx         <= '0;
            o_otp_addr  <= BOOT_BASE;
            state       <= ST_SETUP;
            cnt         <= '0;
            o_otp_csb   <= 1'b0;
            o_otp_load  <= 1'b1;
          end else if (load_done && hif.hif_rd_req) begin
            host_mode   <= 1'b1;
            o_otp_addr  <= hif.hif_rd_addr;
            state       <= ST_SETUP;
            cnt         <= '0;
            o_otp_csb   <= 1'b0;
            o_otp_load  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt == SU_LAST) begin
            state        <= ST_STROBE;
            cnt          <= '0;
            o_otp_strobe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == STB_LAST) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            o_otp_strobe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HLD_LAST) begin
            state      <= ST_RECOVER;
            cnt        <= '0;
            o_otp_csb  <= 1'b1;
            o_otp_load <= 1'b0;
            if (host_mode) begin
              hif.hif_rd_data <= i_otp_q;
              hif.hif_rd_ack  <= 1'b1;
            end else begin
              shadow_data[{idx, 3'b000} +: 8] <= i_otp_q;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (!host_mode && idx != IDX_LAST) begin
            idx        <= idx + 1'b1;
            o_otp_addr <= BOOT_BASE + 10'(idx) + 10'd1;
            state      <= ST_SETUP;
            o_otp_csb  <= 1'b0;
            o_otp_load <= 1'b1;
          end else begin
            if (!host_mode) load_done <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_read_sequencer.sv
// tb/tb_otp_read_sequencer.sv - directed self-checking bench for otp_read_sequencer
module tb_otp_read_sequencer;

  logic         xtal_clk;
  logic         por_rst_n;
  logic         o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_vddqsw;
  logic [9:0]   o_otp_addr;
  logic [7:0]   i_otp_q;
  logic         otp_reload;
  logic [127:0] shadow_data;
  logic         load_done, busy;
  logic [7:0]   mem [0:1023];

  otp_read_sequencer_if hif ();

  otp_read_sequencer dut (
    .xtal_clk     (xtal_clk),
    .por_rst_n    (por_rst_n),
    .o_otp_csb    (o_otp_csb),
    .o_otp_strobe (o_otp_strobe),
    .o_otp_load   (o_otp_load),
    .o_otp_pgenb  (o_otp_pgenb),
    .o_otp_vddqsw (o_otp_vddqsw),
    .o_otp_addr   (o_otp_addr),
    .i_otp_q      (i_otp_q),
    .otp_reload   (otp_reload),
    .hif          (hif.slave),
    .shadow_data  (shadow_data),
    .load_done    (load_done),
    .busy         (busy)
  );

  initial begin
    xtal_clk = 1'b0;
    forever #5 xtal_clk = ~xtal_clk;
  end

  // eFuse model: data only driven while the read path is enabled
  assign i_otp_q = (!o_otp_csb && o_otp_load) ? mem[o_otp_addr] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor
  int   viol = 0;
  int   fall_cnt = 0;
  int   stb_in_win = 0;
  int   stb_w = 0;
  int   last_stb_w = 0;
  logic [9:0] stb_addr = '0;
  logic prev_csb = 1'b1;
  logic prev_stb = 1'b0;

  always @(negedge xtal_clk) begin
    if (por_rst_n) begin
      if (o_otp_pgenb !== 1'b1 || o_otp_vddqsw !== 1'b0) viol++;
      if (o_otp_strobe && (o_otp_csb || !o_otp_load)) viol++;
      if (prev_csb && !o_otp_csb) begin
        fall_cnt++;
        stb_in_win = 0;
      end
      if (o_otp_strobe && !prev_stb) begin
        stb_in_win++;
        if (stb_in_win > 1) viol++;
        stb_w = 1;
        stb_addr = o_otp_addr;
      end else if (o_otp_strobe) begin
        stb_w++;
      end else if (prev_stb) begin
        last_stb_w = stb_w;
      end
    end
    prev_csb = o_otp_csb;
    prev_stb = o_otp_strobe;
  end

  task automatic tick();
    @(posedge xtal_clk);
    @(negedge xtal_clk);
  endtask

  // Runs until load_done; optionally raises a host request at cycle req_at.
  task automatic wait_boot(input int req_at, input logic [9:0] raddr,
                           output int busy_at, output int done_at, output int early_ack);
    int cyc;
    cyc = 0; busy_at = -1; early_ack = 0;
    while (!load_done && cyc < 400) begin
      tick();
      cyc++;
      if (busy && busy_at < 0) busy_at = cyc;
      if (hif.hif_rd_ack) early_ack++;
      if (cyc == req_at) begin
        hif.hif_rd_req  = 1'b1;
        hif.hif_rd_addr = raddr;
      end
    end
    done_at = cyc;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!hif.hif_rd_ack && n < 400) begin
      tick();
      n++;
    end
    hif.hif_rd_req = 1'b0;
  endtask

  int busy_at, done_at, early, n, base;

  initial begin
    por_rst_n       = 1'b0;
    otp_reload      = 1'b0;
    hif.hif_rd_req  = 1'b0;
    hif.hif_rd_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int k = 0; k < 16; k++) mem[k] = 8'hA0 + 8'(k);
    mem[10'h3FF] = 8'h5C;

    repeat (2) @(negedge xtal_clk);
    check("rst_csb",      o_otp_csb, 1'b1);
    check("rst_strobe",   o_otp_strobe, 1'b0);
    check("rst_load",     o_otp_load, 1'b0);
    check("rst_pgenb",    o_otp_pgenb, 1'b1);
    check("rst_vddqsw",   o_otp_vddqsw, 1'b0);
    check("rst_addr",     o_otp_addr, 10'h000);
    check("rst_ack_data", {hif.hif_rd_ack, hif.hif_rd_data}, 9'h000);
    check("rst_shadow",   shadow_data, 128'h0);
    check("rst_done_busy", {load_done, busy}, 2'b00);

    // Boot with a host request raised at cycle 3
    base = fall_cnt;
    por_rst_n = 1'b1;
    wait_boot(3, 10'h3FF, busy_at, done_at, early);
    check("boot_busy_rise", busy_at, 1);
    check("boot_len",       done_at - busy_at, 144);
    check("boot_accesses",  fall_cnt - base, 16);
    check("boot_no_ack",    early, 0);
    check("shadow_b0",      shadow_data[7:0], 8'hA0);
    check("shadow_b5",      shadow_data[47:40], 8'hA5);
    check("shadow_b15",     shadow_data[127:120], 8'hAF);
    wait_ack(n);
    check("early_req_lat",  n, 9);
    check("early_req_data", hif.hif_rd_data, 8'h5C);
    tick();

    // Plain host read of the top address
    tick();
    hif.hif_rd_req  = 1'b1;
    hif.hif_rd_addr = 10'h3FF;
    wait_ack(n);
    check("host_lat",       n, 9);
    check("host_data",      hif.hif_rd_data, 8'h5C);
    check("host_stb_addr",  stb_addr, 10'h3FF);
    check("host_stb_width", last_stb_w, 4);
    tick();
    check("ack_one_cycle",  hif.hif_rd_ack, 1'b0);
    tick();

    // Reload from IDLE, then reset in the middle of boot index 7 strobe
    base = fall_cnt;
    otp_reload = 1'b1;
    tick();
    otp_reload = 1'b0;
    check("reload_start", {busy, load_done}, 2'b10);
    n = 0;
    while (!(fall_cnt - base == 8 && o_otp_strobe) && n < 300) begin
      tick();
      n++;
    end
    check("reach_idx7_strobe", {o_otp_strobe, o_otp_addr}, {1'b1, 10'h007});
    #2 por_rst_n = 1'b0;
    #1;
    check("async_rst_pins", {o_otp_csb, o_otp_strobe, o_otp_load, o_otp_addr}, {3'b100, 10'h000});
    check("async_rst_state", {load_done, busy, shadow_data}, {2'b00, 128'h0});
    @(negedge xtal_clk);
    base = fall_cnt;
    por_rst_n = 1'b1;
    wait_boot(-1, 10'h000, busy_at, done_at, early);
    check("reboot_len",      done_at - busy_at, 144);
    check("reboot_accesses", fall_cnt - base, 16);
    check("reboot_b7",       shadow_data[63:56], 8'hA7);
    tick();

    // Reload and host request together: reload wins
    mem[2] = 8'h33;
    otp_reload      = 1'b1;
    hif.hif_rd_req  = 1'b1;
    hif.hif_rd_addr = 10'h005;
    tick();
    otp_reload = 1'b0;
    check("race_reload_first", {busy, load_done}, 2'b10);
    n = 1;
    while (!hif.hif_rd_ack && n < 400) begin
      tick();
      n++;
    end
    hif.hif_rd_req = 1'b0;
    check("race_ack_after_boot", {hif.hif_rd_ack, load_done}, 2'b11);
    check("race_ack_lat",  n, 154);
    check("race_data",     hif.hif_rd_data, 8'hA5);
    check("race_shadow_b2", shadow_data[23:16], 8'h33);
    tick();
    tick();

    check("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
